// File: rtl/shift_seq.sv
// Multi-cycle shifter/rotator: moves a WIDTH-bit word by a signed count, up to STEP bits
// per clock, reporting the last bit shifted out and the arithmetic-left sign-change flag.
module shift_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 6,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ready,
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   shift,
  input  logic [1:0]       mode,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] out,
  output logic             last_bit,
  output logic             overflow
);

  localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);

  typedef enum logic [1:0] {IDLE, RUN, DONE, WAIT} state_t;
  typedef enum logic [1:0] {
    MODE_ARITH = 2'b00,
    MODE_LOGIC = 2'b01,
    MODE_ROT   = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_t;

  state_t       state;
  mode_t        mode_q;
  logic         dir;
  logic [SHW:0] rem;

  // One extra bit so the most negative count negates without wrapping.
  logic [SHW:0] shift_ext;
  logic [SHW:0] shift_mag;
  assign shift_ext = {shift[SHW-1], shift};
  assign shift_mag = shift[SHW-1] ? -shift_ext : shift_ext;

  logic [SHW:0] step_n;
  assign step_n = (rem < STEP_W) ? rem : STEP_W;

  logic             arith;
  logic             rot;
  assign arith = (mode_q == MODE_ARITH);
  assign rot   = (mode_q == MODE_ROT);

  logic [WIDTH-1:0] word;
  logic             lb;
  logic             ov;

  // Up to STEP single-bit stages; only the first step_n of them are enabled this cycle.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latch can be inferred.
    word = out;
    lb   = last_bit;
    ov   = overflow;
    for (int i = 0; i < STEP; i++) begin
      if ((SHW+1)'(i) < step_n) begin
        // NOTE: blocking assignments here so each stage sees the previous stage's result.
        if (!dir) begin
          lb = word[WIDTH-1];
          if (arith && (word[WIDTH-1] != word[WIDTH-2])) ov = 1'b1;
          word = {word[WIDTH-2:0], rot ? word[WIDTH-1] : 1'b0};
        end else begin
          lb   = word[0];
          word = {rot ? word[0] : (arith & word[WIDTH-1]), word[WIDTH-1:1]};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state    <= IDLE;
      mode_q   <= MODE_ARITH;
      dir      <= 1'b0;
      rem      <= '0;
      out      <= '0;
      last_bit <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (ready) begin
            out      <= in;
            rem      <= shift_mag;
            dir      <= shift[SHW-1];
            mode_q   <= mode_t'(mode);
            last_bit <= 1'b0;
            overflow <= 1'b0;
            busy     <= (shift_mag != '0);
            state    <= (shift_mag != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          out      <= word;
          last_bit <= lb;
          overflow <= ov;
          rem      <= rem - step_n;
          if (rem <= STEP_W) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= ready ? WAIT : IDLE;
        end
        WAIT: begin
          done <= 1'b0;
          if (!ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
